// File: rtl/divide_iter_if.sv
`default_nettype none
// ============================================================================
// divide_iter_if : operand/result handshake bundle for divide_iter
// Revision       : 1.0
// ============================================================================
interface divide_iter_if #(
    parameter int D_WIDTH   = 32,
    parameter int TAG_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [D_WIDTH-1:0]   dividend;
    logic [D_WIDTH-1:0]   divisor;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [D_WIDTH-1:0]   quotient;
    logic [D_WIDTH-1:0]   remainder;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 div_zero;
    logic                 overflow;

    modport master (
        output in_valid, dividend, divisor, in_tag, out_ready,
        input  in_ready, out_valid, quotient, remainder, out_tag, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, in_tag, out_ready,
        output in_ready, out_valid, quotient, remainder, out_tag, div_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/divide_iter.sv
`default_nettype none
// ============================================================================
// divide_iter : signed Q-format iterative restoring divider with handshake,
//               tag passthrough, divide-by-zero and overflow saturation
// Revision    : 1.0
// ============================================================================
module divide_iter #(
    parameter int Q_BITS         = 10,
    parameter int D_WIDTH        = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_WIDTH      = 8
) (
    input  logic         clock,
    input  logic         reset,
    divide_iter_if.slave bus
);
    localparam int c_NUM_W = D_WIDTH + Q_BITS;
    localparam int c_ITER  = c_NUM_W / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_ITER + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [c_NUM_W-1:0] c_POS_LIM = {{(Q_BITS+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic [c_NUM_W-1:0] c_NEG_LIM = c_POS_LIM + c_NUM_W'(1);
    localparam logic [D_WIDTH-1:0] c_SAT_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] c_SAT_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_NUM_W-1:0]   r_num;
    logic [D_WIDTH-1:0]   r_rem;
    logic [D_WIDTH-1:0]   r_dvs;
    logic                 r_neg_a;
    logic                 r_neg_q;
    logic [TAG_WIDTH-1:0] r_tag;

    logic [D_WIDTH-1:0]   r_quotient;
    logic [D_WIDTH-1:0]   r_remainder;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_div_zero;
    logic                 r_overflow;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [D_WIDTH-1:0]   w_abs_a;
    logic [D_WIDTH-1:0]   w_abs_b;
    logic [D_WIDTH:0]     w_shift;
    logic [D_WIDTH:0]     w_diff;
    logic                 w_ge;
    logic [D_WIDTH-1:0]   w_rem_step;
    logic [c_NUM_W-1:0]   w_num_step;
    logic                 w_ovf;
    logic [D_WIDTH-1:0]   w_q_fixed;
    logic [D_WIDTH-1:0]   w_r_fixed;

    // Negating MIN wraps back to MIN, which read unsigned is exactly |MIN|.
    assign w_abs_a = bus.dividend[D_WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_abs_b = bus.divisor[D_WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // r_num shifts numerator bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        w_rem_step = r_rem;
        w_num_step = r_num;
        w_shift    = '0;
        w_diff     = '0;
        w_ge       = 1'b0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_shift    = {w_rem_step, w_num_step[c_NUM_W-1]};
            w_diff     = w_shift - {1'b0, r_dvs};
            w_ge       = (w_shift >= {1'b0, r_dvs});
            w_rem_step = w_ge ? w_diff[D_WIDTH-1:0] : w_shift[D_WIDTH-1:0];
            w_num_step = {w_num_step[c_NUM_W-2:0], w_ge};
        end
    end

    assign w_ovf     = r_neg_q ? (r_num > c_NEG_LIM) : (r_num > c_POS_LIM);
    assign w_q_fixed = r_neg_q ? -r_num[D_WIDTH-1:0] : r_num[D_WIDTH-1:0];
    assign w_r_fixed = r_neg_a ? -r_rem : r_rem;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (bus.in_valid) w_next_state = (bus.divisor == '0) ? c_FIX : c_CALC;
            c_CALC: if (r_cnt == c_CNT_W'(c_ITER - 1)) w_next_state = c_FIX;
            c_FIX:  w_next_state = c_DONE;
            c_DONE: if (bus.out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == c_IDLE);
        w_out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_num       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_neg_a     <= 1'b0;
            r_neg_q     <= 1'b0;
            r_tag       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_out_tag   <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: if (bus.in_valid) begin
                    r_num   <= c_NUM_W'(w_abs_a) << Q_BITS;
                    r_rem   <= '0;
                    r_dvs   <= w_abs_b;
                    r_neg_a <= bus.dividend[D_WIDTH-1];
                    r_neg_q <= bus.dividend[D_WIDTH-1] ^ bus.divisor[D_WIDTH-1];
                    r_tag   <= bus.in_tag;
                    r_cnt   <= '0;
                end
                c_CALC: begin
                    r_num <= w_num_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                c_FIX: begin
                    r_out_tag <= r_tag;
                    if (r_dvs == '0) begin
                        r_quotient  <= r_neg_a ? c_SAT_NEG : c_SAT_POS;
                        r_remainder <= '0;
                        r_div_zero  <= 1'b1;
                        r_overflow  <= 1'b0;
                    end else if (w_ovf) begin
                        r_quotient  <= r_neg_q ? c_SAT_NEG : c_SAT_POS;
                        r_remainder <= '0;
                        r_div_zero  <= 1'b0;
                        r_overflow  <= 1'b1;
                    end else begin
                        r_quotient  <= w_q_fixed;
                        r_remainder <= w_r_fixed;
                        r_div_zero  <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.out_tag   = r_out_tag;
    assign bus.div_zero  = r_div_zero;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_divide_iter.sv
`default_nettype none
// ============================================================================
// tb_divide_iter : scoreboard bench for divide_iter (1 and 2 bits per cycle)
// Revision       : 1.0
// ============================================================================
module tb_divide_iter;
    localparam int     c_Q    = 10;
    localparam int     c_DW   = 32;
    localparam int     c_TW   = 8;
    localparam int     c_LAT1 = (c_DW + c_Q) / 1 + 1;
    localparam int     c_LAT2 = (c_DW + c_Q) / 2 + 1;
    localparam longint c_LMAX = 64'sd2147483647;
    localparam longint c_LMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [7:0]  tag;
        logic        dz;
        logic        ov;
        int          acc;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    divide_iter_if #(.D_WIDTH(c_DW), .TAG_WIDTH(c_TW)) m0 ();
    divide_iter_if #(.D_WIDTH(c_DW), .TAG_WIDTH(c_TW)) m1 ();

    divide_iter #(.Q_BITS(c_Q), .D_WIDTH(c_DW), .BITS_PER_CYCLE(1), .TAG_WIDTH(c_TW)) dut0 (
        .clock(clock), .reset(reset), .bus(m0.slave));
    divide_iter #(.Q_BITS(c_Q), .D_WIDTH(c_DW), .BITS_PER_CYCLE(2), .TAG_WIDTH(c_TW)) dut1 (
        .clock(clock), .reset(reset), .bus(m1.slave));

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_chk = 0, n_pass = 0, n_to = 0;
    int   cyc = 0;
    logic rst_hit = 1'b0;
    int   rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    bit          hold    [2] = '{0, 0};
    bit          prev_v  [2] = '{0, 0};
    int          first_v [2] = '{0, 0};
    logic [63:0] snap_qr [2];
    logic [9:0]  snap_f  [2];

    // Reference: plain integer division of the scaled numerator, C-style truncation.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [7:0] tag, input int lat);
        exp_t e;
        longint num, den, q, r;
        e.tag = tag; e.dz = 1'b0; e.ov = 1'b0; e.lat = lat; e.acc = 0;
        num = longint'($signed(a)) * (longint'(1) << c_Q);
        if (b == 32'h0) begin
            e.dz = 1'b1;
            e.q  = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            e.r  = 32'h0;
            e.lat = 1;
        end else begin
            den = longint'($signed(b));
            q = num / den;
            r = num % den;
            if (q > c_LMAX || q < c_LMIN) begin
                e.ov = 1'b1;
                e.q  = (q > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                e.r  = 32'h0;
            end else begin
                e.q = q[31:0];
                e.r = r[31:0];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_op(input bit is_div);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = $urandom;
            1:       v = $urandom_range(1, 1 << 20);
            2:       v = is_div ? 32'h0 : 32'h7FFF_FFFF;
            3:       v = is_div ? 32'hFFFF_FFFF : 32'h8000_0000;
            4:       v = $urandom >> $urandom_range(8, 31);
            default: v = $urandom_range(1, 1 << 16) << c_Q;
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mon(input int d);
        logic v, rdy, ir, dz, ov;
        logic [31:0] q, r;
        logic [7:0]  t;
        string p;
        exp_t e;
        int pending;
        p = $sformatf("dut%0d.", d);
        if (d == 0) begin
            v = m0.out_valid; rdy = m0.out_ready; ir = m0.in_ready; q = m0.quotient;
            r = m0.remainder; t = m0.out_tag; dz = m0.div_zero; ov = m0.overflow;
            pending = sb0.size();
        end else begin
            v = m1.out_valid; rdy = m1.out_ready; ir = m1.in_ready; q = m1.quotient;
            r = m1.remainder; t = m1.out_tag; dz = m1.div_zero; ov = m1.overflow;
            pending = sb1.size();
        end
        if (rst_hit) begin
            chk({p, "reset_out_valid"}, 64'(v), 64'd0);
            chk({p, "reset_in_ready"}, 64'(ir), 64'd1);
            chk({p, "reset_q_r"}, {q, r}, 64'd0);
            chk({p, "reset_tag_flags"}, 64'({t, dz, ov}), 64'd0);
            hold[d] = 1'b0; prev_v[d] = 1'b0;
            return;
        end
        if (hold[d]) begin
            chk({p, "hold_valid"}, 64'(v), 64'd1);
            chk({p, "hold_q_r"}, {q, r}, snap_qr[d]);
            chk({p, "hold_tag_flags"}, 64'({t, dz, ov}), 64'(snap_f[d]));
        end
        if (v) chk({p, "in_ready_while_valid"}, 64'(ir), 64'd0);
        if (v && !prev_v[d]) first_v[d] = cyc;
        prev_v[d] = v;
        if (v && rdy) begin
            chk({p, "result_expected"}, 64'(pending > 0), 64'd1);
            if (pending > 0) begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk({p, "quotient"}, 64'(q), 64'(e.q));
                chk({p, "remainder"}, 64'(r), 64'(e.r));
                chk({p, "out_tag"}, 64'(t), 64'(e.tag));
                chk({p, "div_zero"}, 64'(dz), 64'(e.dz));
                chk({p, "overflow"}, 64'(ov), 64'(e.ov));
                chk({p, "latency"}, 64'(first_v[d] - e.acc), 64'(e.lat));
            end
        end
        hold[d]    = v && !rdy;
        snap_qr[d] = {q, r};
        snap_f[d]  = {t, dz, ov};
    endtask

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        rst_hit <= !reset;
    end

    always @(posedge clock) begin
        #2;
        case (rdy_mode)
            1:       begin m0.out_ready = ($urandom_range(0, 3) != 0); m1.out_ready = ($urandom_range(0, 3) != 0); end
            2:       begin m0.out_ready = 1'b0; m1.out_ready = 1'b0; end
            default: begin m0.out_ready = 1'b1; m1.out_ready = 1'b1; end
        endcase
    end

    always @(negedge clock) begin
        if (cyc >= 1) begin
            mon(0);
            mon(1);
        end
    end

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
        exp_t e;
        int waited;
        bit ok;
        @(negedge clock);
        if (d == 0) begin m0.in_valid = 1'b1; m0.dividend = a; m0.divisor = b; m0.in_tag = tag; end
        else        begin m1.in_valid = 1'b1; m1.dividend = a; m1.divisor = b; m1.in_tag = tag; end
        waited = 0; ok = 1'b0;
        while (!ok && waited < 500) begin
            if ((d == 0 && m0.in_ready === 1'b1) || (d == 1 && m1.in_ready === 1'b1)) ok = 1'b1;
            else begin @(negedge clock); waited++; end
        end
        if (ok) begin
            e = model(a, b, tag, (d == 0) ? c_LAT1 : c_LAT2);
            e.acc = cyc + 1;
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end else begin
            $display("FAIL dut%0d.accept_timeout: in_ready low for %0d cycles, required 1", d, waited);
            n_to++;
        end
        @(negedge clock);
        // Operands only matter on the accepting edge; scramble them afterwards.
        if (d == 0) begin m0.in_valid = 1'b0; m0.dividend = $urandom; m0.divisor = $urandom; end
        else        begin m1.in_valid = 1'b0; m1.dividend = $urandom; m1.divisor = $urandom; end
    endtask

    task automatic drain(input int limit);
        int i = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && i < limit) begin
            @(negedge clock);
            i++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            $display("FAIL drain_timeout: outstanding %0d/%0d results, required 0/0", sb0.size(), sb1.size());
            n_to++;
        end
    endtask

    initial begin
        int i;
        reset = 1'b0;
        m0.in_valid = 1'b0; m0.dividend = '0; m0.divisor = '0; m0.in_tag = '0;
        m1.in_valid = 1'b0; m1.dividend = '0; m1.divisor = '0; m1.in_tag = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        issue(0, 190 << 10, 7 << 10, 8'h11);
        issue(1, 190 << 10, 7 << 10, 8'h12);
        issue(0, -(190 << 10), 7 << 10, 8'h21);
        issue(0, 190 << 10, -(7 << 10), 8'h22);
        issue(0, -(190 << 10), -(7 << 10), 8'h23);
        issue(0, 5 << 10, 0, 8'h31);
        issue(0, -(5 << 10), 0, 8'h32);
        issue(0, 32'h7FFF_FFFF, 32'h1, 8'h41);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h42);
        drain(500);

        // Backpressure: a second offer must wait out a 10-cycle stall.
        rdy_mode = 2;
        issue(0, 1000 << 10, 3 << 10, 8'h51);
        i = 0;
        while (m0.out_valid !== 1'b1 && i < 100) begin @(negedge clock); i++; end
        if (m0.out_valid !== 1'b1) begin
            $display("FAIL dut0.valid_timeout: out_valid stayed low, required 1");
            n_to++;
        end
        fork
            issue(0, -(12345 << 10), 77 << 10, 8'h52);
            begin
                repeat (10) @(negedge clock);
                rdy_mode = 0;
            end
        join
        drain(500);

        // Reset in the middle of an iteration run.
        issue(0, 190 << 10, 7 << 10, 8'h61);
        repeat (19) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb0.delete();
        issue(0, 333 << 10, -(9 << 10), 8'h62);
        drain(500);

        rdy_mode = 1;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    issue(0, rnd_op(1'b0), rnd_op(1'b1), 8'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                end
            end
            begin
                for (int j = 0; j < 12; j++)
                    issue(1, rnd_op(1'b0), rnd_op(1'b1), 8'($urandom));
            end
        join
        drain(3000);
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk + n_to);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/divide_iter.md
Name: divide_iter

Overview:
- Parametrised, handshaked successor to the fixed-point divide block.
- Computes signed Q-format quotient = (dividend << Q_BITS) / divisor, plus a remainder, using an iterative restoring divider that retires BITS_PER_CYCLE quotient bits per clock.
- Adds ready/valid backpressure, a passthrough tag, divide-by-zero and overflow flags with saturation.
- Sits between the ray/triangle intersection math and downstream consumers that may stall.

Parameters:
- Q_BITS, 10, fractional bits of operands and quotient.
- D_WIDTH, 32, width of dividend, divisor, quotient and remainder (two's complement).
- BITS_PER_CYCLE, 1, quotient bits produced per iteration; (D_WIDTH+Q_BITS) % BITS_PER_CYCLE must be 0.
- TAG_WIDTH, 8, width of the sideband tag carried with each operation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  D_WIDTH  signed Q-format dividend.
- divisor  in  D_WIDTH  signed Q-format divisor.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  D_WIDTH  signed Q-format quotient.
- remainder  out  D_WIDTH  signed remainder.
- out_tag  out  TAG_WIDTH  tag of this result.
- div_zero  out  1  divisor was 0.
- overflow  out  1  quotient saturated.

Behaviour:
- Define ITER = (D_WIDTH+Q_BITS)/BITS_PER_CYCLE; with defaults, ITER = 42.
- Reset: reset low at a rising edge forces the following, regardless of state or in-flight operation; that operation is discarded.
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - quotient, remainder and out_tag = 0
  - div_zero and overflow = 0
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch magnitudes |dividend| and |divisor| as unsigned D_WIDTH values (|MIN| = 2^(D_WIDTH-1) is representable), the signs, and the tag.
  - Numerator magnitude is |dividend| << Q_BITS (D_WIDTH+Q_BITS bits).
  - If divisor == 0, go to FIX; otherwise go to CALC with the iteration counter at 0.
- CALC:
  - in_ready = 0.
  - Each cycle performs BITS_PER_CYCLE restoring shift/subtract steps, MSB first.
  - After ITER cycles, go to FIX.
- FIX (one cycle):
  - Quotient sign = sign(dividend) XOR sign(divisor); truncate toward zero.
  - Remainder takes the dividend's sign and satisfies num = q*divisor + r with |r| < |divisor|.
  - Overflow when magnitude > 2^(D_WIDTH-1)-1 for a positive result, or > 2^(D_WIDTH-1) for a negative result. On overflow: quotient saturates to 0x7FF..F or 0x800..0, remainder = 0, overflow = 1.
  - Divide by zero: quotient = 0x7FF..F if dividend >= 0, else 0x800..0; remainder = 0; div_zero = 1; overflow = 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; all outputs are held stable while out_ready = 0.
  - On out_ready, go to IDLE with out_valid = 0 on the next edge.
  - Outputs keep their last values until the next FIX.
- Latency (accepting edge T):
  - Normal operation: out_valid is high after edge T+ITER+1.
  - Divide by zero: out_valid is high after edge T+1.
- Throughput: in_ready is low from the accepting edge until the edge after the output handshake. No input is accepted in the same cycle as an output handshake.
- in_valid is ignored outside IDLE; operands need only be valid on the accepting edge.

Test Plan:
- Basic positive case, defaults: dividend = 190<<10, divisor = 7<<10, out_ready = 1.
  - Expect quotient = 27794 (0x6C92), remainder = 2048, flags = 0.
  - out_valid first high 43 cycles after acceptance; out_tag echoes in_tag.
- Sign handling: dividend = -(190<<10), divisor = 7<<10.
  - Expect quotient = -27794, remainder = -2048.
  - Repeat with divisor = -(7<<10): quotient = -27794, remainder = +2048.
- Divide by zero: dividend = 5<<10, divisor = 0.
  - Expect quotient = 0x7FFFFFFF, remainder = 0, div_zero = 1, out_valid after 1 cycle.
  - With dividend = -5<<10: quotient = 0x80000000.
- Overflow: dividend = 0x7FFFFFFF, divisor = 1 → quotient = 0x7FFFFFFF, overflow = 1.
- Overflow: dividend = 0x80000000, divisor = -1 → quotient = 0x7FFFFFFF, overflow = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid.
  - Outputs and out_valid stay stable; in_ready stays 0; an offered second operation is not accepted.
  - After out_ready pulses, the second operation is accepted in IDLE and produces correct results.
- Reset mid-operation: pull reset low during CALC iteration 20.
  - Next edge: out_valid = 0, in_ready = 1, all outputs 0.
  - A new operation then completes with the normal latency.
- Rerun the basic positive case with BITS_PER_CYCLE = 2: identical results, out_valid at T+22.
